// File: rtl/fft_fp_pkg.sv
// Shared types and helpers for the FFT floating-point butterfly datapath.
package fft_fp_pkg;
  typedef logic [31:0] fp32_t;

  typedef struct packed {
    fp32_t re;
    fp32_t im;
  } cplx_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} bfly_state_e;

  localparam logic OP_ADD       = 1'b0;
  localparam logic OP_SUB       = 1'b1;
  localparam int   BFLY_NUM_OPS = 4;
  localparam int   TAG_W        = 3;

  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
  } fpu_tag_t;

  // Op order: x_re, x_im, y_re, y_im -> idx[0] picks im, idx[1] picks subtract.
  function automatic fp32_t op_src(input cplx_t c, input logic [1:0] idx);
    return idx[0] ? c.im : c.re;
  endfunction

  function automatic logic op_sel(input logic [1:0] idx);
    return idx[1] ? OP_SUB : OP_ADD;
  endfunction
endpackage

// File: rtl/fpu_tag_pipe.sv
// Tag shift register that tracks in-flight FPU ops, aligned to the FPU latency.
module fpu_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int W     = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_tag,
  output logic [W-1:0] o_tag
);
  logic [DEPTH-1:0][W-1:0] r_pipe;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_tag;
      for (int k = 1; k < DEPTH; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  assign o_tag = r_pipe[DEPTH-1];
endmodule

// File: rtl/fpu_bfly_sched.sv
// Radix-2 butterfly scheduler: four add/sub ops time-multiplexed onto one shared FPU.
module fpu_bfly_sched
  import fft_fp_pkg::*;
#(
  parameter int FPU_LAT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_a_re,
  input  logic [31:0] i_a_im,
  input  logic [31:0] i_b_re,
  input  logic [31:0] i_b_im,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_x_re,
  output logic [31:0] o_x_im,
  output logic [31:0] o_y_re,
  output logic [31:0] o_y_im,
  output logic        o_fpu_add_sub,
  output logic [31:0] o_fpu_a,
  output logic [31:0] o_fpu_b,
  input  logic [31:0] i_fpu_s
);
  bfly_state_e                 r_state;
  logic [1:0]                  r_cnt;
  cplx_t                       r_a, r_b;
  fp32_t [BFLY_NUM_OPS-1:0]    r_res;
  logic                        r_fpu_add_sub;
  fp32_t                       r_fpu_a, r_fpu_b;
  fpu_tag_t                    w_tag_in, w_tag_out;
  logic [1:0]                  w_nxt;

  assign w_nxt = r_cnt + 2'd1;

  // Tag tracks the op currently on the FPU inputs, so it emerges with its result.
  always_comb begin
    w_tag_in     = '0;
    w_tag_in.vld = (r_state == ISSUE);
    w_tag_in.idx = r_cnt;
  end

  fpu_tag_pipe #(.DEPTH(FPU_LAT), .W(TAG_W)) u_tag_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_tag   (w_tag_in),
    .o_tag   (w_tag_out)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_res         <= '0;
      r_fpu_add_sub <= OP_ADD;
      r_fpu_a       <= '0;
      r_fpu_b       <= '0;
    end else begin
      if (w_tag_out.vld) r_res[w_tag_out.idx] <= i_fpu_s;
      case (r_state)
        IDLE: if (i_valid) begin
          r_a           <= '{re: i_a_re, im: i_a_im};
          r_b           <= '{re: i_b_re, im: i_b_im};
          r_cnt         <= '0;
          r_fpu_a       <= i_a_re;
          r_fpu_b       <= i_b_re;
          r_fpu_add_sub <= OP_ADD;
          r_state       <= ISSUE;
        end
        ISSUE: if (r_cnt == 2'(BFLY_NUM_OPS - 1)) begin
          r_fpu_a       <= '0;
          r_fpu_b       <= '0;
          r_fpu_add_sub <= OP_ADD;
          r_state       <= WAIT;
        end else begin
          r_cnt         <= w_nxt;
          r_fpu_a       <= op_src(r_a, w_nxt);
          r_fpu_b       <= op_src(r_b, w_nxt);
          r_fpu_add_sub <= op_sel(w_nxt);
        end
        WAIT: if (w_tag_out.vld && (w_tag_out.idx == 2'(BFLY_NUM_OPS - 1))) r_state <= DONE;
        DONE: if (i_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ready       = (r_state == IDLE);
  assign o_valid       = (r_state == DONE);
  assign o_x_re        = r_res[0];
  assign o_x_im        = r_res[1];
  assign o_y_re        = r_res[2];
  assign o_y_im        = r_res[3];
  assign o_fpu_add_sub = r_fpu_add_sub;
  assign o_fpu_a       = r_fpu_a;
  assign o_fpu_b       = r_fpu_b;
endmodule
